imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 28 ++
 rtl/imem_word_packer.sv | 32 +++
 rtl/imem_boot_loader.sv | 129 ++++++++++++
 tb/tb_imem_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The header is a little-endian word count that precedes the data bytes.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      DONE,
      ERR
   } load_state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_WIDTH    = 8 * HDR_BYTES;

   // The fetch path is frozen for every state that belongs to an active load.
   function automatic logic holds_cpu(input load_state_t s);
      return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == WRITE);
   endfunction

   function automatic logic takes_bytes(input load_state_t s);
      return (s == HDR0) || (s == HDR1) || (s == DATA);
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian host bytes into a 32-bit word, one lane per byte.
// word_full flags the byte that completes the current word.
module imem_word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] byte_idx;

   assign word_full = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

   // Lanes are overwritten in order, so stale bytes from an aborted word never survive a full word.
   always_ff @(posedge clk) begin
      if (rst) begin
         word     <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (byte_valid) begin
         word[{byte_idx, 3'b000} +: 8] <= byte_in;
         byte_idx                      <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a host byte stream (2-byte count header, then words)
// while holding the fetch stage, and restarts fetch at address 0 on success.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  fetch_restart,
   output logic                  load_done,
   output logic                  load_err,
   output logic [ADDR_WIDTH-2:0] words_loaded
);

   localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_WORDS);

   load_state_t            state;
   load_state_t            next_state;
   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] hdr_count;
   logic [COUNT_WIDTH-1:0] next_word;
   logic [ADDR_WIDTH-2:0]  word_idx;
   logic                   accept;
   logic                   pack_en;
   logic                   pack_clear;
   logic                   word_full;

   assign accept       = in_valid && in_ready;
   assign hdr_count    = {in_data, count[7:0]};
   assign next_word    = COUNT_WIDTH'(word_idx) + COUNT_WIDTH'(1);
   assign pack_en      = accept && (state == DATA) && !abort;
   assign words_loaded = word_idx;

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pack_clear),
      .byte_valid (pack_en),
      .byte_in    (in_data),
      .word       (mem_wdata),
      .word_full  (word_full)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Abort outranks every normal transition; a WRITE already on the bus still lands.
   always_comb begin
      next_state = state;
      pack_clear = 1'b0;
      case (state)
         IDLE: begin
            if (start) next_state = HDR0;
         end
         HDR0: begin
            if (abort)       next_state = ERR;
            else if (accept) next_state = HDR1;
         end
         HDR1: begin
            if (abort) begin
               next_state = ERR;
            end else if (accept) begin
               if ((hdr_count == '0) || (hdr_count > MAX_COUNT)) begin
                  next_state = ERR;
               end else begin
                  next_state = DATA;
                  pack_clear = 1'b1;
               end
            end
         end
         DATA: begin
            if (abort)          next_state = ERR;
            else if (word_full) next_state = WRITE;
         end
         WRITE: begin
            if (abort)                  next_state = ERR;
            else if (next_word == count) next_state = DONE;
            else                        next_state = DATA;
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so each one is valid during the state it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready      <= 1'b0;
         cpu_hold      <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         load_done     <= 1'b0;
         fetch_restart <= 1'b0;
         load_err      <= 1'b0;
         count         <= '0;
         word_idx      <= '0;
      end else begin
         in_ready      <= takes_bytes(next_state);
         cpu_hold      <= holds_cpu(next_state);
         mem_we        <= (next_state == WRITE);
         load_done     <= (next_state == DONE);
         fetch_restart <= (next_state == DONE);
         load_err      <= (next_state == ERR);
         if ((state == HDR0) && accept) count[7:0]  <= in_data;
         if ((state == HDR1) && accept) count[15:8] <= in_data;
         if (next_state == WRITE) mem_addr <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
         if (((state == IDLE) && start) || pack_clear) begin
            word_idx <= '0;
         end else if (state == WRITE) begin
            word_idx <= word_idx + (ADDR_WIDTH-1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a load model queues expected writes and
// completion events, and a negedge monitor compares them against the DUT.
module tb_imem_boot_loader;

   localparam int ADDR_WIDTH = 10;
   localparam int MAX_WORDS  = 256;
   localparam int EVT_DONE   = 0;
   localparam int EVT_ERR    = 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  abort;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  cpu_hold;
   logic                  fetch_restart;
   logic                  load_done;
   logic                  load_err;
   logic [ADDR_WIDTH-2:0] words_loaded;

   int          checks   = 0;
   int          failures = 0;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_evt[$];
   logic [7:0]  stream[$];
   int          last_addr = -1;

   imem_boot_loader #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_WORDS  (MAX_WORDS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .fetch_restart (fetch_restart),
      .load_done     (load_done),
      .load_err      (load_err),
      .words_loaded  (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   // Monitor: every write and completion pulse must match the head of its queue.
   initial begin
      int a;
      int e;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_we) begin
               if (exp_addr.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_write addr=0x%0h data=0x%0h required no write", mem_addr, mem_wdata);
               end else begin
                  a = exp_addr.pop_front();
                  d = exp_data.pop_front();
                  check_output("write_addr", 32'(mem_addr), 32'(a));
                  check_output("write_data", mem_wdata, d);
               end
               check_output("ready_during_write", 32'(in_ready), 32'(0));
               check_output("hold_during_write", 32'(cpu_hold), 32'(1));
               last_addr = int'(mem_addr);
            end
            if (load_done || load_err || fetch_restart) begin
               if (exp_evt.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_event done=%0b err=%0b restart=%0b required none",
                           load_done, load_err, fetch_restart);
               end else begin
                  e = exp_evt.pop_front();
                  check_output("evt_done", 32'(load_done), 32'(e == EVT_DONE));
                  check_output("evt_err", 32'(load_err), 32'(e == EVT_ERR));
                  check_output("evt_restart", 32'(fetch_restart), 32'(e == EVT_DONE));
                  check_output("evt_hold_released", 32'(cpu_hold), 32'(0));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_in_ready"}, 32'(in_ready), 32'(0));
      check_output({tag, "_mem_we"}, 32'(mem_we), 32'(0));
      check_output({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
      check_output({tag, "_mem_wdata"}, mem_wdata, 32'(0));
      check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(0));
      check_output({tag, "_fetch_restart"}, 32'(fetch_restart), 32'(0));
      check_output({tag, "_load_done"}, 32'(load_done), 32'(0));
      check_output({tag, "_load_err"}, 32'(load_err), 32'(0));
      check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'(0));
   endtask

   // Called and returns on a negedge; the byte is taken on the posedge in between.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int n;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL handshake_timeout in_ready=%0b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic fill_stream(input int n);
      stream.delete();
      repeat (n) stream.push_back(8'($urandom));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_addr.size() != 0 || exp_evt.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_addr.size() != 0 || exp_evt.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout pending_writes=%0d pending_events=%0d required 0",
                  exp_addr.size(), exp_evt.size());
         exp_addr.delete();
         exp_data.delete();
         exp_evt.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Reference model: a valid count yields one write per complete 4-byte group sent
   // (word w at byte address 4w, little-endian), then DONE only if all words arrived.
   task automatic expect_load(input int count, input int n_send, input bit aborted, output int n_words);
      bit ok;
      ok = (count != 0) && (count <= MAX_WORDS);
      n_words = 0;
      if (!ok) begin
         exp_evt.push_back(EVT_ERR);
      end else begin
         n_words = n_send / 4;
         for (int w = 0; w < n_words; w++) begin
            exp_addr.push_back(4 * w);
            exp_data.push_back({stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]});
         end
         if (aborted)                 exp_evt.push_back(EVT_ERR);
         else if (n_send == 4*count)  exp_evt.push_back(EVT_DONE);
      end
   endtask

   task automatic apply_stimulus(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                                 input int n_send, input bit do_abort, input int start_mid_at,
                                 input int max_gap);
      int count;
      int n_words;
      count = int'({hi, lo});
      expect_load(count, n_send, do_abort, n_words);
      pulse_start();
      check_output({tag, "_hold_at_hdr"}, 32'(cpu_hold), 32'(1));
      check_output({tag, "_ready_at_hdr"}, 32'(in_ready), 32'(1));
      send_byte(lo, max_gap);
      send_byte(hi, max_gap);
      if ((count != 0) && (count <= MAX_WORDS)) begin
         for (int i = 0; i < n_send; i++) begin
            send_byte(stream[i], max_gap);
            if (i == start_mid_at) pulse_start();
         end
      end
      if (do_abort) begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      wait_drain();
      check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'(n_words));
      check_output({tag, "_hold_released"}, 32'(cpu_hold), 32'(0));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("idle");

      stream = '{8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
      apply_stimulus("happy", 8'h02, 8'h00, 8, 1'b0, -1, 0);

      apply_stimulus("count_zero", 8'h00, 8'h00, 0, 1'b0, -1, 1);

      begin
         int n_words;
         exp_evt.push_back(EVT_ERR);
         pulse_start();
         send_byte(8'h01, 0);
         send_byte(8'h01, 0);
         pulse_start();
         check_output("start_in_err_ignored_ready", 32'(in_ready), 32'(0));
         check_output("start_in_err_ignored_hold", 32'(cpu_hold), 32'(0));
         wait_drain();
         n_words = 0;
         check_output("count_257_words_loaded", 32'(words_loaded), 32'(n_words));
      end

      fill_stream(12);
      apply_stimulus("abort", 8'h03, 8'h00, 6, 1'b1, -1, 1);

      fill_stream(12);
      apply_stimulus("start_in_data", 8'h03, 8'h00, 12, 1'b0, 2, 2);

      fill_stream(4 * MAX_WORDS);
      apply_stimulus("capacity", 8'h00, 8'h01, 4 * MAX_WORDS, 1'b0, -1, 2);
      check_output("capacity_last_addr", 32'(last_addr), 32'h3FC);

      fill_stream(12);
      begin
         int n_words;
         expect_load(3, 4, 1'b0, n_words);
         pulse_start();
         send_byte(8'h03, 0);
         send_byte(8'h00, 0);
         for (int i = 0; i < 5; i++) send_byte(stream[i], 1);
         rst = 1'b1;
         @(negedge clk);
         check_reset_outputs("mid_reset");
         rst = 1'b0;
         @(negedge clk);
         wait_drain();
      end

      fill_stream(8);
      apply_stimulus("after_reset", 8'h02, 8'h00, 8, 1'b0, -1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
